// File: rtl/stopwatch_lap_core.sv
// Single-clock stopwatch/timer: prescaled 0.1 s enable driving an M:SS.t BCD cascade,
// with count-up/down, preload, lap capture and wrap-or-stop terminal behaviour.
module stopwatch_lap_core #(
  parameter int unsigned TICK_DIV  = 10000000,
  parameter int unsigned MIN_LIMIT = 9,
  parameter bit          WRAP      = 1'b0
) (
  input  logic        clk_main,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dir,
  input  logic        lap,
  output logic [15:0] live_digits,
  output logic [15:0] disp_digits,
  output logic        running,
  output logic        lap_hold,
  output logic        done,
  output logic        tick
);

  localparam int unsigned      PSC_W   = $clog2(TICK_DIV);
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TICK_DIV - 1);
  localparam logic [3:0]       MIN_D   = 4'(MIN_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [15:0]      live_q, live_d;
  logic [15:0]      lap_q, lap_d;
  logic [15:0]      disp_q, disp_d;
  logic             dir_q, dir_d;
  logic             lap_hold_q, lap_hold_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             tick_q, tick_d;

  logic        load_ok;
  logic        run_step;
  logic        zero_stall;
  logic        tick_ev;
  logic [3:0]  d0, d1, d2, d3;
  logic [15:0] up_val, dn_val, step_val, ld_val;
  logic        up_term, step_term;

  assign {d3, d2, d1, d0} = live_q;

  // Event decode: clear > load (ignored in RUN) > start_stop > counting.
  assign load_ok    = load && (state_q != S_RUN);
  assign run_step   = (state_q == S_RUN) && !clear && !start_stop;
  assign zero_stall = run_step && dir_q && (live_q == '0) && (WRAP == 1'b0);
  assign tick_ev    = run_step && !zero_stall && (psc_q == PSC_MAX);

  always_comb begin
    up_val  = live_q;
    up_term = 1'b0;
    if (d0 < 4'd9) begin
      up_val[3:0] = d0 + 4'd1;
    end else begin
      up_val[3:0] = '0;
      if (d1 < 4'd9) begin
        up_val[7:4] = d1 + 4'd1;
      end else begin
        up_val[7:4] = '0;
        if (d2 < 4'd5) begin
          up_val[11:8] = d2 + 4'd1;
        end else begin
          up_val[11:8] = '0;
          if (d3 < MIN_D) begin
            up_val[15:12] = d3 + 4'd1;
          end else begin
            up_val[15:12] = '0;
            up_term       = 1'b1;
          end
        end
      end
    end
  end

  // Borrowing from 0:00.0 naturally yields MIN_LIMIT:59.9, which is the WRAP=1 reload.
  always_comb begin
    dn_val = live_q;
    if (d0 != 4'd0) begin
      dn_val[3:0] = d0 - 4'd1;
    end else begin
      dn_val[3:0] = 4'd9;
      if (d1 != 4'd0) begin
        dn_val[7:4] = d1 - 4'd1;
      end else begin
        dn_val[7:4] = 4'd9;
        if (d2 != 4'd0) begin
          dn_val[11:8] = d2 - 4'd1;
        end else begin
          dn_val[11:8] = 4'd5;
          if (d3 != 4'd0) begin
            dn_val[15:12] = d3 - 4'd1;
          end else begin
            dn_val[15:12] = MIN_D;
          end
        end
      end
    end
  end

  always_comb begin
    step_val  = live_q;
    step_term = 1'b0;
    if (dir_q) begin
      step_val  = dn_val;
      step_term = (dn_val == '0);
    end else begin
      step_val  = (up_term && (WRAP == 1'b0)) ? live_q : up_val;
      step_term = up_term;
    end
  end

  always_comb begin
    ld_val[15:12] = (load_val[15:12] > MIN_D) ? MIN_D : load_val[15:12];
    ld_val[11:8]  = (load_val[11:8] > 4'd5) ? 4'd5 : load_val[11:8];
    ld_val[7:4]   = (load_val[7:4] > 4'd9) ? 4'd9 : load_val[7:4];
    ld_val[3:0]   = (load_val[3:0] > 4'd9) ? 4'd9 : load_val[3:0];
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = (state_q == S_RUN) ? S_RUN : S_IDLE;
    end else if (load_ok) begin
      state_d = (state_q == S_DONE) ? S_IDLE : state_q;
    end else if (start_stop) begin
      unique case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end else if (zero_stall) begin
      state_d = S_DONE;
    end else if (tick_ev && step_term && (WRAP == 1'b0)) begin
      state_d = S_DONE;
    end
  end

  always_comb begin
    psc_d  = psc_q;
    live_d = live_q;
    tick_d = 1'b0;
    if (clear) begin
      psc_d  = '0;
      live_d = '0;
    end else if (load_ok) begin
      psc_d  = '0;
      live_d = ld_val;
    end else if (zero_stall) begin
      psc_d = '0;
    end else if (run_step) begin
      if (tick_ev) begin
        psc_d  = '0;
        live_d = step_val;
        tick_d = 1'b1;
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  always_comb begin
    dir_d      = (state_q != S_RUN) ? dir : dir_q;
    lap_d      = lap_q;
    lap_hold_d = lap_hold_q;
    if (clear) begin
      lap_hold_d = 1'b0;
    end else if (lap) begin
      if (!lap_hold_q) begin
        lap_d      = live_q;
        lap_hold_d = 1'b1;
      end else begin
        lap_hold_d = 1'b0;
      end
    end
  end

  always_comb begin
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    disp_d    = lap_hold_d ? lap_d : live_d;
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      psc_q      <= '0;
      live_q     <= '0;
      lap_q      <= '0;
      disp_q     <= '0;
      dir_q      <= 1'b0;
      lap_hold_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      psc_q      <= psc_d;
      live_q     <= live_d;
      lap_q      <= lap_d;
      disp_q     <= disp_d;
      dir_q      <= dir_d;
      lap_hold_q <= lap_hold_d;
      running_q  <= running_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
    end
  end

  assign live_digits = live_q;
  assign disp_digits = disp_q;
  assign running     = running_q;
  assign lap_hold    = lap_hold_q;
  assign done        = done_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core: three instances sharing stimulus
// (MIN 9 / no wrap, MIN 1 / no wrap, MIN 1 / wrap), all with TICK_DIV=4.
module tb_stopwatch_lap_core;

  logic        clk;
  logic        reset, start_stop, clear, load, dir, lap;
  logic [15:0] load_val;

  logic [15:0] a_live, a_disp, b_live, b_disp, c_live, c_disp;
  logic        a_run, a_lh, a_done, a_tick;
  logic        b_run, b_lh, b_done, b_tick;
  logic        c_run, c_lh, c_done, c_tick;

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_lap_core #(.TICK_DIV(4), .MIN_LIMIT(9), .WRAP(1'b0)) dut_a (
    .clk_main(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .load(load), .load_val(load_val), .dir(dir), .lap(lap),
    .live_digits(a_live), .disp_digits(a_disp), .running(a_run),
    .lap_hold(a_lh), .done(a_done), .tick(a_tick));

  stopwatch_lap_core #(.TICK_DIV(4), .MIN_LIMIT(1), .WRAP(1'b0)) dut_b (
    .clk_main(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .load(load), .load_val(load_val), .dir(dir), .lap(lap),
    .live_digits(b_live), .disp_digits(b_disp), .running(b_run),
    .lap_hold(b_lh), .done(b_done), .tick(b_tick));

  stopwatch_lap_core #(.TICK_DIV(4), .MIN_LIMIT(1), .WRAP(1'b1)) dut_c (
    .clk_main(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .load(load), .load_val(load_val), .dir(dir), .lap(lap),
    .live_digits(c_live), .disp_digits(c_disp), .running(c_run),
    .lap_hold(c_lh), .done(c_done), .tick(c_tick));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0; load = 1'b0;
    dir = 1'b0; lap = 1'b0; load_val = '0;
    cyc(2);
    reset = 1'b0;
    chk("rst_live", a_live, 16'h0000);
    chk("rst_disp", a_disp, 16'h0000);
    chk("rst_running", {15'b0, a_run}, 16'd0);
    chk("rst_lap_hold", {15'b0, a_lh}, 16'd0);
    chk("rst_done", {15'b0, a_done}, 16'd0);
    chk("rst_tick", {15'b0, a_tick}, 16'd0);

    // Start: running rises, first tick four edges later.
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    chk("start_running", {15'b0, a_run}, 16'd1);
    cyc(3);
    chk("pre_tick_none", {15'b0, a_tick}, 16'd0);
    chk("pre_tick_live", a_live, 16'h0000);
    cyc(1);
    chk("first_tick", {15'b0, a_tick}, 16'd1);
    chk("first_tick_live", a_live, 16'h0001);
    cyc(396);
    chk("100_ticks_live", a_live, 16'h0100);
    chk("100_ticks_tick", {15'b0, a_tick}, 16'd1);

    // Pause two cycles into a tenth; partial tenth must survive.
    cyc(2);
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    chk("pause_running", {15'b0, a_run}, 16'd0);
    cyc(20);
    chk("pause_live", a_live, 16'h0100);
    chk("pause_tick", {15'b0, a_tick}, 16'd0);
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    chk("resume_running", {15'b0, a_run}, 16'd1);
    cyc(1);
    chk("resume_no_tick", {15'b0, a_tick}, 16'd0);
    cyc(1);
    chk("resume_tick", {15'b0, a_tick}, 16'd1);
    chk("resume_live", a_live, 16'h0101);

    // Clear while running stays running from zero.
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("run_clear_live", a_live, 16'h0000);
    chk("run_clear_running", {15'b0, a_run}, 16'd1);
    cyc(92);
    chk("reach_0023", a_live, 16'h0023);

    // Lap freeze / release / coincident capture.
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_hold_set", {15'b0, a_lh}, 16'd1);
    chk("lap_disp", a_disp, 16'h0023);
    cyc(8);
    chk("lap_live_adv", a_live, 16'h0025);
    chk("lap_disp_frozen", a_disp, 16'h0023);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_release_hold", {15'b0, a_lh}, 16'd0);
    chk("lap_release_disp", a_disp, 16'h0025);
    cyc(1);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_coinc_tick", {15'b0, a_tick}, 16'd1);
    chk("lap_coinc_live", a_live, 16'h0026);
    chk("lap_coinc_disp", a_disp, 16'h0025);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_coinc_release", a_disp, 16'h0026);

    // Priority while paused: clear wins over load and start_stop.
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    clear = 1'b1; load = 1'b1; load_val = 16'h1234; start_stop = 1'b1;
    cyc(1);
    clear = 1'b0; load = 1'b0; start_stop = 1'b0;
    chk("prio_live", a_live, 16'h0000);
    chk("prio_running", {15'b0, a_run}, 16'd0);

    // Up terminal with MIN_LIMIT=1: stop (b) versus wrap (c).
    load_val = 16'h1599;
    load = 1'b1; cyc(1); load = 1'b0;
    chk("load_1599", b_live, 16'h1599);
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    cyc(4);
    chk("term_b_live", b_live, 16'h1599);
    chk("term_b_done", {15'b0, b_done}, 16'd1);
    chk("term_b_running", {15'b0, b_run}, 16'd0);
    chk("term_c_live", c_live, 16'h0000);
    chk("term_c_running", {15'b0, c_run}, 16'd1);
    chk("term_c_done", {15'b0, c_done}, 16'd0);
    chk("term_a_live", a_live, 16'h2000);
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    chk("done_ss_ignored", {15'b0, b_done}, 16'd1);
    chk("done_ss_no_run", {15'b0, b_run}, 16'd0);

    // Count down from 0:01.0.
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clear_done_b", {15'b0, b_done}, 16'd0);
    dir = 1'b1; load_val = 16'h0010;
    load = 1'b1; cyc(1); load = 1'b0;
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    cyc(4);
    chk("down_first", a_live, 16'h0009);
    cyc(32);
    chk("down_0001", a_live, 16'h0001);
    chk("down_not_done", {15'b0, a_done}, 16'd0);
    cyc(4);
    chk("down_zero", a_live, 16'h0000);
    chk("down_done", {15'b0, a_done}, 16'd1);
    chk("down_stopped", {15'b0, a_run}, 16'd0);
    chk("down_c_running", {15'b0, c_run}, 16'd1);
    cyc(4);
    chk("down_c_reload", c_live, 16'h1599);
    chk("down_a_hold", a_live, 16'h0000);

    // Count-down started at zero without wrap ends the cycle after starting.
    clear = 1'b1; cyc(1); clear = 1'b0;
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    chk("zero_start_running", {15'b0, a_run}, 16'd1);
    cyc(1);
    chk("zero_start_done", {15'b0, a_done}, 16'd1);
    chk("zero_start_stopped", {15'b0, a_run}, 16'd0);

    // Load clamping and load leaving DONE.
    dir = 1'b0; load_val = 16'hFFFF;
    load = 1'b1; cyc(1); load = 1'b0;
    chk("clamp_a", a_live, 16'h9599);
    chk("clamp_b", b_live, 16'h1599);
    chk("load_exit_done", {15'b0, a_done}, 16'd0);

    // Load ignored in RUN, then mid-run reset.
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("run_lap_hold", {15'b0, a_lh}, 16'd1);
    load_val = 16'h1234;
    load = 1'b1; cyc(1); load = 1'b0;
    chk("run_load_ignored", a_live, 16'h9599);
    chk("run_load_running", {15'b0, a_run}, 16'd1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    chk("mid_rst_live", a_live, 16'h0000);
    chk("mid_rst_disp", a_disp, 16'h0000);
    chk("mid_rst_running", {15'b0, a_run}, 16'd0);
    chk("mid_rst_lap_hold", {15'b0, a_lh}, 16'd0);
    chk("mid_rst_done", {15'b0, a_done}, 16'd0);
    chk("mid_rst_tick", {15'b0, a_tick}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
